// File: rtl/cache_arb_types.sv
// Shared types for the L1-to-L2 line arbiter: FSM states, client identifiers
// and the line width the L2 memory port is built around.
package cache_arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } arb_client_t;

  localparam int ARB_LINE_BITS = 256;

endpackage

// File: rtl/register.sv
// Generic load-enabled register with synchronous active-high clear.
module register #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between the L1 I-cache and L1 D-cache in front of L2.
// The granted request is latched so the L2 port stays stable while L1 inputs move.
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int s_line = ARB_LINE_BITS,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_addr-1:0] i_address,
  input  logic              i_read,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic [s_addr-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic [s_addr-1:0] mem_address,
  output logic [s_line-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t  state_reg;
  arb_client_t last_grant_reg;

  logic              pend_i;
  logic              pend_d;
  logic              pick_d;
  logic              load;
  logic              load_wdata;
  logic [s_addr-1:0] address_next;
  logic              op_next;
  logic              op_hold;
  logic              granted;

  // D wins a tie only when I was the client served most recently.
  always_comb begin
    pend_i       = i_read;
    pend_d       = d_read | d_write;
    pick_d       = pend_d & (~pend_i | (last_grant_reg == CLIENT_I));
    load         = (state_reg == IDLE) & (pend_i | pend_d);
    load_wdata   = load & pick_d;
    address_next = pick_d ? d_address : i_address;
    op_next      = pick_d & d_write;
  end

  register #(.width(s_addr)) address_hold (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (address_next),
    .q    (mem_address)
  );

  register #(.width(s_line)) wdata_hold (
    .clk  (clk),
    .rst  (rst),
    .load (load_wdata),
    .d    (d_wdata),
    .q    (mem_wdata)
  );

  // op_hold: 1 = write, 0 = read.
  register #(.width(1)) op_hold_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (op_next),
    .q    (op_hold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= CLIENT_I;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (load) begin
            state_reg <= pick_d ? GRANT_D : GRANT_I;
          end
        end
        GRANT_I: begin
          if (mem_resp) begin
            last_grant_reg <= CLIENT_I;
            state_reg      <= RECOVER;
          end
        end
        GRANT_D: begin
          if (mem_resp) begin
            last_grant_reg <= CLIENT_D;
            state_reg      <= RECOVER;
          end
        end
        RECOVER: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Responses pass straight through so the client sees zero added latency.
  always_comb begin
    granted   = (state_reg == GRANT_I) | (state_reg == GRANT_D);
    mem_read  = granted & ~op_hold;
    mem_write = granted & op_hold;
    i_resp    = (state_reg == GRANT_I) & mem_resp;
    d_resp    = (state_reg == GRANT_D) & mem_resp;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs driven and outputs sampled on the
// falling edge, one line printed per transaction.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_address;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_address;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;

  logic [255:0] line_a5;
  logic [255:0] line_beef;
  logic [255:0] line_cafe;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_address   (i_address),
    .i_read      (i_read),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_address   (d_address),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = 32'h0; d_address = 32'h0; d_wdata = '0; mem_rdata = '0;
    tick();
    tick();
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL reset_mem_ops: read=%b write=%b required 0 0", mem_read, mem_write);
    end
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++; $display("FAIL reset_resp: i=%b d=%b required 0 0", i_resp, d_resp);
    end
    checks++;
    if (mem_address !== 32'h0 || mem_wdata !== 256'h0) begin
      errors++; $display("FAIL reset_hold: addr=%h wdata=%h required 0", mem_address, mem_wdata);
    end
    rst = 1'b0;
    tick();
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_lone_i_read();
    i_read = 1'b1; i_address = 32'h0000_1000;
    tick();                                   // cycle 1
    #1;
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h1000) begin
      errors++; $display("FAIL lone_i_grant: read=%b write=%b addr=%h required 1 0 00001000", mem_read, mem_write, mem_address);
    end
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    #1;
    checks++;
    if (i_resp !== 1'b0) begin
      errors++; $display("FAIL lone_i_early_resp: i_resp=%b required 0", i_resp);
    end
    tick();                                   // cycle 4
    mem_rdata = line_a5; mem_resp = 1'b1;
    #1;
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== line_a5) begin
      errors++; $display("FAIL lone_i_resp: i_resp=%b i_rdata=%h required 1 %h", i_resp, i_rdata, line_a5);
    end
    checks++;
    if (d_resp !== 1'b0) begin
      errors++; $display("FAIL lone_i_d_resp: d_resp=%b required 0", d_resp);
    end
    tick();                                   // RECOVER
    mem_resp = 1'b0; i_read = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || i_resp !== 1'b0) begin
      errors++; $display("FAIL lone_i_recover: mem_read=%b i_resp=%b required 0 0", mem_read, i_resp);
    end
    tick();                                   // IDLE
    $display("lone_i_read: addr=00001000 served");
  endtask

  task automatic test_d_write();
    d_write = 1'b1; d_address = 32'h0000_2040; d_wdata = line_beef;
    tick();
    #1;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
      errors++; $display("FAIL d_write_ops: write=%b read=%b required 1 0", mem_write, mem_read);
    end
    checks++;
    if (mem_wdata !== line_beef || mem_address !== 32'h2040) begin
      errors++; $display("FAIL d_write_data: wdata=%h addr=%h required %h 00002040", mem_wdata, mem_address, line_beef);
    end
    tick();
    mem_resp = 1'b1;
    #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      errors++; $display("FAIL d_write_resp: d_resp=%b i_resp=%b required 1 0", d_resp, i_resp);
    end
    tick();
    mem_resp = 1'b0; d_write = 1'b0;
    #1;
    checks++;
    if (d_resp !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL d_write_pulse: d_resp=%b mem_write=%b required 0 0", d_resp, mem_write);
    end
    tick();
    $display("d_write: addr=00002040 written");
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_read = 1'b1; i_address = 32'h100;
    d_read = 1'b1; d_address = 32'h200;
    tick();
    #1;
    checks++;
    if (mem_address !== 32'h200 || mem_read !== 1'b1) begin
      errors++; $display("FAIL simul_first_d: addr=%h read=%b required 00000200 1", mem_address, mem_read);
    end
    mem_resp = 1'b1;                          // cycle m
    #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      errors++; $display("FAIL simul_d_resp: d=%b i=%b required 1 0", d_resp, i_resp);
    end
    tick();                                   // m+1 RECOVER
    mem_resp = 1'b0; d_read = 1'b0;
    tick();                                   // m+2 IDLE
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      errors++; $display("FAIL simul_gap: mem_read=%b required 0", mem_read);
    end
    tick();                                   // m+3 GRANT_I
    #1;
    checks++;
    if (mem_address !== 32'h100 || mem_read !== 1'b1) begin
      errors++; $display("FAIL simul_then_i: addr=%h read=%b required 00000100 1", mem_address, mem_read);
    end
    mem_resp = 1'b1;
    #1;
    checks++;
    if (i_resp !== 1'b1) begin
      errors++; $display("FAIL simul_i_resp: i_resp=%b required 1", i_resp);
    end
    tick();
    mem_resp = 1'b0; i_read = 1'b0;
    tick();
    $display("simultaneous: D then I granted");
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr;
    int i_cnt = 0;
    int d_cnt = 0;
    do_reset();
    i_read = 1'b1; i_address = 32'h100;
    d_read = 1'b1; d_address = 32'h200;
    for (int t = 0; t < 6; t++) begin
      tick();                                 // grant cycle
      exp_addr = (t % 2 == 0) ? 32'h200 : 32'h100;
      #1;
      checks++;
      if (mem_address !== exp_addr || mem_read !== 1'b1) begin
        errors++; $display("FAIL contention_order[%0d]: addr=%h read=%b required %h 1", t, mem_address, mem_read, exp_addr);
      end
      mem_resp = 1'b1;
      #1;
      if (i_resp === 1'b1) i_cnt++;
      if (d_resp === 1'b1) d_cnt++;
      $display("contention: txn %0d addr=%h i_resp=%b d_resp=%b", t, mem_address, i_resp, d_resp);
      tick();                                 // RECOVER
      mem_resp = 1'b0;
      tick();                                 // IDLE
    end
    checks++;
    if (i_cnt !== 3 || d_cnt !== 3) begin
      errors++; $display("FAIL contention_counts: i=%0d d=%0d required 3 3", i_cnt, d_cnt);
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
  endtask

  task automatic test_input_change();
    do_reset();
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h300; d_wdata = line_cafe;
    tick();
    #1;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
      errors++; $display("FAIL rw_is_write: write=%b read=%b required 1 0", mem_write, mem_read);
    end
    d_address = 32'h400; d_write = 1'b0; d_wdata = line_a5;
    tick();
    #1;
    checks++;
    if (mem_address !== 32'h300 || mem_write !== 1'b1 || mem_wdata !== line_cafe) begin
      errors++; $display("FAIL hold_stable: addr=%h write=%b wdata=%h required 00000300 1 %h", mem_address, mem_write, mem_wdata, line_cafe);
    end
    mem_resp = 1'b1;
    #1;
    checks++;
    if (d_resp !== 1'b1) begin
      errors++; $display("FAIL change_resp: d_resp=%b required 1", d_resp);
    end
    tick();
    mem_resp = 1'b0; d_read = 1'b0;
    tick();
    $display("input_change: addr held at 00000300 as write");
  endtask

  task automatic test_reset_mid_grant();
    i_read = 1'b1; i_address = 32'h0000_0800;
    tick();
    #1;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h800) begin
      errors++; $display("FAIL midrst_grant: read=%b addr=%h required 1 00000800", mem_read, mem_address);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; i_read = 1'b0;
    mem_resp = 1'b1;                          // stray response while idle
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: read=%b write=%b required 0 0", mem_read, mem_write);
    end
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++; $display("FAIL midrst_stray: i=%b d=%b required 0 0", i_resp, d_resp);
    end
    tick();
    mem_resp = 1'b0;
    d_read = 1'b1; d_address = 32'h500;
    tick();
    #1;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h500) begin
      errors++; $display("FAIL midrst_next_d: read=%b addr=%h required 1 00000500", mem_read, mem_address);
    end
    mem_resp = 1'b1;
    #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      errors++; $display("FAIL midrst_d_resp: d=%b i=%b required 1 0", d_resp, i_resp);
    end
    tick();
    mem_resp = 1'b0; d_read = 1'b0;
    tick();
    $display("reset_mid_grant: I dropped, D served at 00000500");
  endtask

  initial begin
    line_a5   = {32{8'hA5}};
    line_beef = {8{32'hDEADBEEF}};
    line_cafe = {8{32'hCAFEF00D}};
    test_reset();
    test_lone_i_read();
    test_d_write();
    test_simultaneous();
    test_contention();
    test_input_change();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
